// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit: fetch FSM states,
// {PCBsrc,PCAsrc} select encodings and the sequential step size.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_REG = 2'b11;

  localparam int PC_STEP = 4;

  function automatic logic is_redirect(input logic valid, input logic [1:0] sel);
    return valid && (sel != PC_SEQ);
  endfunction

endpackage

// File: rtl/next_pc_adder.sv
// Redirect target: (b_src ? rs1 : pc) + (a_src ? imm : 4), wrapping, with
// bit 0 cleared for register-based (jalr) targets.
module next_pc_adder
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            pc_b_src,
  input  logic            pc_a_src,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  always_comb begin
    base   = pc_b_src ? ex_rs1 : ex_pc;
    offset = pc_a_src ? ex_imm : XLEN'(PC_STEP);
    target = base + offset;
    if (pc_b_src) target[0] = 1'b0;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder and one-outstanding instruction fetcher with branch redirect.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned targets raise sticky fetch_misalign and park fetch.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_pc_b_src,
  input  logic            ex_pc_a_src,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_misalign,
`endif
  output fetch_state_t    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once valid is raised it and its payload hold until that transfer.

  fetch_state_t    state_q, state_d, resume_state;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            pend_q, pend_d;
  logic            kill_q, kill_d;
  logic            redirect, park;
  logic [XLEN-1:0] target_raw, target;

  next_pc_adder #(.XLEN(XLEN)) u_next_pc_adder (
    .pc_b_src (ex_pc_b_src),
    .pc_a_src (ex_pc_a_src),
    .ex_pc    (ex_pc),
    .ex_rs1   (ex_rs1),
    .ex_imm   (ex_imm),
    .target   (target_raw)
  );

  assign redirect = is_redirect(ex_valid, {ex_pc_b_src, ex_pc_a_src});

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_hit;

  assign target       = target_raw;
  assign misalign_hit = redirect && (target_raw[1:0] != 2'b00);
  assign park         = misalign_q || misalign_hit;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_q || misalign_hit;
  end
`else
  assign target = target_raw & ~XLEN'(3);
  assign park   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    resume_state = park ? IDLE : REQ;
    unique case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = target;
        state_d = resume_state;
      end
      REQ: begin
        // The request address must not move before acceptance, so a redirect
        // is parked in pend_pc and applied when the stale request goes out.
        if (imem_req_ready) begin
          state_d = WAIT;
          pend_d  = 1'b0;
          if (redirect) begin
            fetch_pc_d = target;
            kill_d     = 1'b1;
          end else if (pend_q) begin
            fetch_pc_d = pend_pc_q;
            kill_d     = 1'b1;
          end
        end else if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = resume_state;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q || park) begin
            kill_d  = 1'b0;
            state_d = resume_state;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = fetch_pc_q;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = resume_state;
        end else if (inst_ready) begin
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == REQ);
    imem_addr      = fetch_pc_q;
    inst_valid     = (state_q == HOLD);
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed redirect scenarios plus randomized traffic
// against a fetch-stream reference model and a pseudo-random memory image.
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid, ex_pc_b_src, ex_pc_a_src;
  logic [31:0]  ex_pc, ex_rs1, ex_imm;
  logic         imem_req_valid, imem_req_ready;
  logic [31:0]  imem_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         inst_valid, inst_ready;
  logic [31:0]  inst, inst_pc;
  fetch_state_t state_dbg;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic         fetch_misalign;
`endif

  pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_pc_b_src     (ex_pc_b_src),
    .ex_pc_a_src     (ex_pc_a_src),
    .ex_pc           (ex_pc),
    .ex_rs1          (ex_rs1),
    .ex_imm          (ex_imm),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign  (fetch_misalign),
`endif
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] exp_q[$];        // expected addresses of upcoming accepted requests
  logic [31:0] exp_pc;          // address decode must see next
  logic        exp_mis = 1'b0;
  int          delivered = 0;
  int          n_req = 0;

  // memory / decode driver configuration: 0 = always ready, 1 = never, 2 = random
  int          cfg_req = 0, cfg_dec = 0;
  int          lat_lo = 1, lat_hi = 1;
  logic        override = 1'b0;
  logic [31:0] override_data = '0;
  int          resp_cnt = 0;
  logic [31:0] resp_word = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] rs1, input logic [31:0] imm);
    logic [31:0] t;
    t = (sel[1] ? rs1 : pc) + (sel[0] ? imm : 32'd4);
    if (sel[1]) t[0] = 1'b0;
`ifndef FETCH_MISALIGN_CHECK_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  function automatic logic pick(input int cfg);
    if (cfg == 0) return 1'b1;
    if (cfg == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: check outputs, drive memory/decode/execute, advance the model.
  task automatic step(input logic rv, input logic [1:0] sel, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] imm);
    if (prev_stall) begin
      check_eq("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check_eq("req_hold_addr", imem_addr, prev_addr);
    end
    if (exp_mis) begin
      check_eq("parked_inst", 32'(inst_valid), 32'd0);
    end else if (inst_valid) begin
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst_word", inst, mem_word(exp_pc));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("misalign_flag", 32'(fetch_misalign), 32'(exp_mis));
`endif
    inst_ready      = pick(cfg_dec);
    imem_req_ready  = pick(cfg_req);
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = resp_word;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check_eq("one_outstanding", 32'((resp_cnt != 0) || imem_resp_valid), 32'd0);
      if (exp_q.size() > 0) check_eq("req_addr", imem_addr, exp_q.pop_front());
      n_req++;
      resp_cnt  = int'($urandom_range(lat_hi, lat_lo));
      resp_word = override ? override_data : mem_word(imem_addr);
      override  = 1'b0;
    end
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_addr;
    ex_valid   = rv;
    if (rv) begin
      {ex_pc_b_src, ex_pc_a_src} = sel;
      ex_pc  = pc;
      ex_rs1 = rs1;
      ex_imm = imm;
    end else begin
      {ex_pc_b_src, ex_pc_a_src} = 2'($urandom_range(0, 3));
      ex_pc  = $urandom;
      ex_rs1 = $urandom;
      ex_imm = $urandom;
    end
    if (rv && sel != PC_SEQ) begin
      exp_pc = ref_target(sel, pc, rs1, imm);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (exp_pc[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    end else if (inst_valid && inst_ready) begin
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, PC_SEQ, '0, '0, '0);
  endtask

  task automatic wait_inst(input string tag);
    int k = 0;
    while (!inst_valid && k < 60) begin
      idle(1);
      k++;
    end
    check_eq(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n0 = n_req;
    int k = 0;
    while (n_req == n0 && k < 60) begin
      idle(1);
      k++;
    end
    check_eq(tag, 32'(n_req != n0), 32'd1);
  endtask

  task automatic wait_delivery(input string tag);
    int d0 = delivered;
    int k = 0;
    while (delivered == d0 && k < 80) begin
      idle(1);
      k++;
    end
    check_eq(tag, 32'(delivered != d0), 32'd1);
  endtask

  initial begin
    logic [31:0] stall_addr;
    int          d0, n0, k;
    ex_valid = 1'b0; ex_pc_b_src = 1'b0; ex_pc_a_src = 1'b0;
    ex_pc = '0; ex_rs1 = '0; ex_imm = '0;
    imem_req_ready = 1'b0; inst_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_imem_addr", imem_addr, RESET_PC);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    imem_resp_valid = 1'b0;
    exp_pc = RESET_PC;

    // sequential fetch 0x0, 0x4, 0x8 with a single-cycle memory
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    k = 0;
    while (delivered < 2 && k < 40) begin
      idle(1);
      k++;
    end
    check_eq("seq_two_delivered", 32'(delivered), 32'd2);
    cfg_dec = 1;
    wait_inst("seq_hold_8");
    check_eq("seq_inst_pc_8", inst_pc, 32'h8);

    // redirect while holding 0x8
    exp_q.push_back(32'h108);
    step(1'b1, PC_IMM, 32'h8, $urandom, 32'h100);
    check_eq("hold_redirect_drop", 32'(inst_valid), 32'd0);
    wait_inst("hold_redirect_inst");
    check_eq("hold_redirect_q", 32'(exp_q.size()), 32'd0);

    // jalr with odd rs1
    exp_q.push_back(32'h2010);
    step(1'b1, PC_REG, $urandom, 32'h2001, 32'h10);
    wait_inst("jalr_inst");
    check_eq("jalr_q", 32'(exp_q.size()), 32'd0);

    // redirect while waiting on a response that must be discarded
    cfg_dec = 0; lat_lo = 2; lat_hi = 2;
    exp_q.push_back(32'h2014); exp_q.push_back(32'h340);
    override = 1'b1; override_data = 32'hDEAD_BEEF;
    wait_req("wait_accept");
    step(1'b1, PC_IMM, 32'h300, $urandom, 32'h40);
    wait_delivery("wait_redirect_deliver");
    check_eq("wait_redirect_q", 32'(exp_q.size()), 32'd0);

    // redirect while the request is stalled for three cycles
    lat_lo = 1; lat_hi = 1; cfg_req = 1;
    k = 0;
    while (!imem_req_valid && k < 40) begin
      idle(1);
      k++;
    end
    stall_addr = imem_addr;
    check_eq("stall_addr", stall_addr, exp_pc);
    exp_q.push_back(stall_addr); exp_q.push_back(32'h520);
    step(1'b1, PC_IMM, 32'h500, $urandom, 32'h20);
    idle(2);
    check_eq("stall_addr_stable", imem_addr, stall_addr);
    cfg_req = 0;
    wait_delivery("stall_redirect_deliver");
    check_eq("stall_redirect_q", 32'(exp_q.size()), 32'd0);

    // randomized traffic
    cfg_req = 2; cfg_dec = 2; lat_lo = 1; lat_hi = 3;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [1:0]  sel;
        logic [31:0] pc, rs1, imm;
        case ($urandom_range(0, 2))
          0:       sel = PC_IMM;
          1:       sel = 2'b10;
          default: sel = PC_REG;
        endcase
        pc = $urandom; rs1 = $urandom; imm = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
        pc[1:0] = 2'b00; rs1[1:0] = 2'b00; imm[1:0] = 2'b00;
`endif
        step(1'b1, sel, pc, rs1, imm);
      end else begin
        idle(1);
      end
    end
    check_eq("rand_progress", 32'(delivered > d0 + 100), 32'd1);

    // misaligned target 0x102
    cfg_req = 0; cfg_dec = 1; lat_lo = 1; lat_hi = 1;
    wait_inst("mis_hold");
`ifdef FETCH_MISALIGN_CHECK_EN
    step(1'b1, PC_IMM, 32'h100, $urandom, 32'h2);
    idle(5);
    check_eq("mis_flag_set", 32'(fetch_misalign), 32'd1);
    n0 = n_req;
    idle(20);
    check_eq("mis_parked_reqs", 32'(n_req - n0), 32'd0);
`else
    exp_q.push_back(32'h100);
    step(1'b1, PC_IMM, 32'h100, $urandom, 32'h2);
    wait_inst("mis_forced_inst");
    check_eq("mis_forced_q", 32'(exp_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
